shifter_stage: RTL and testbench

Operand-2 stage feeding the data-processing ALU. It takes decoded data-processing fields plus register-file read values and applies the ARM barrel-shifter rules for immediate-rotate, immediate-shift and register-shift operands. It produces the registered `opcode`, `a` and `b` triple the ALU consumes, plus the shifter carry-out for later CPSR C-flag update. The stage uses a valid/ready handshake on both sides. Register-specified shifts take one extra internal cycle, matching ARM7 I-cycle timing.

---
 rtl/shifter_stage.sv | 170 +++++++++++++++++
 tb/tb_shifter_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_stage.sv
// Operand-2 barrel-shifter stage in front of the data-processing ALU.
// Immediate and imm-shift operands load in one cycle; register shifts spend one extra cycle in RSHIFT.
module shifter_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_opcode,
    input  logic        in_imm,
    input  logic [7:0]  in_imm8,
    input  logic [3:0]  in_rot,
    input  logic        in_shift_reg,
    input  logic [1:0]  in_shift_type,
    input  logic [4:0]  in_shift_imm,
    input  logic [31:0] rn_val,
    input  logic [31:0] rm_val,
    input  logic [31:0] rs_val,
    input  logic        cpsr_c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_opcode,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic        out_shc
);

    typedef enum logic [1:0] {EMPTY, RSHIFT, FULL} state_t;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [31:0] rn;
        logic [31:0] rm;
        logic [7:0]  rs;
        logic [1:0]  stype;
        logic        c;
    } rs_req_t;

    state_t      state;
    rs_req_t     lat;
    logic        accept;
    logic        is_reg;
    logic [32:0] dir_res;
    logic [32:0] rs_res;

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] r);
        ror32 = (r == 5'd0) ? x : ((x >> r) | (x << (6'd32 - {1'b0, r})));
    endfunction

    // Shift by 1..31; result packed as {carry, value}.
    function automatic logic [32:0] shift_nz(input logic [1:0] st, input logic [4:0] n,
                                             input logic [31:0] rm);
        logic [32:0] t;
        logic [31:0] r;
        t = '0;
        r = '0;
        case (st)
            2'b00: begin
                t = {1'b0, rm} << n;
                shift_nz = t;
            end
            2'b01: begin
                t = {rm, 1'b0} >> n;
                shift_nz = {t[0], t[32:1]};
            end
            2'b10: begin
                t = $signed({rm, 1'b0}) >>> n;
                shift_nz = {t[0], t[32:1]};
            end
            default: begin
                r = ror32(rm, n);
                shift_nz = {r[31], r};
            end
        endcase
    endfunction

    function automatic logic [32:0] imm_shift(input logic [1:0] st, input logic [4:0] n,
                                              input logic [31:0] rm, input logic c);
        if (n != 5'd0) begin
            imm_shift = shift_nz(st, n, rm);
        end else begin
            // Zero amount encodes LSR#32, ASR#32 and RRX.
            case (st)
                2'b00:   imm_shift = {c, rm};
                2'b01:   imm_shift = {rm[31], 32'h0};
                2'b10:   imm_shift = {rm[31], {32{rm[31]}}};
                default: imm_shift = {rm[0], c, rm[31:1]};
            endcase
        end
    endfunction

    function automatic logic [32:0] reg_shift(input logic [1:0] st, input logic [7:0] n,
                                              input logic [31:0] rm, input logic c);
        reg_shift = {c, rm};
        if (n != 8'd0) begin
            case (st)
                2'b00: begin
                    if (n < 8'd32)       reg_shift = shift_nz(st, n[4:0], rm);
                    else if (n == 8'd32) reg_shift = {rm[0], 32'h0};
                    else                 reg_shift = 33'h0;
                end
                2'b01: begin
                    if (n < 8'd32)       reg_shift = shift_nz(st, n[4:0], rm);
                    else if (n == 8'd32) reg_shift = {rm[31], 32'h0};
                    else                 reg_shift = 33'h0;
                end
                2'b10: begin
                    if (n < 8'd32) reg_shift = shift_nz(st, n[4:0], rm);
                    else           reg_shift = {rm[31], {32{rm[31]}}};
                end
                default: begin
                    if (n[4:0] == 5'd0) reg_shift = {rm[31], rm};
                    else                reg_shift = shift_nz(st, n[4:0], rm);
                end
            endcase
        end
    endfunction

    assign in_ready  = (state == EMPTY) || ((state == FULL) && out_ready);
    assign out_valid = (state == FULL);
    assign accept    = in_valid && in_ready;
    assign is_reg    = in_shift_reg && !in_imm;

    always_comb begin
        logic [31:0] r;
        r = ror32({24'h0, in_imm8}, {in_rot, 1'b0});
        if (in_imm) dir_res = {(in_rot == 4'd0) ? cpsr_c : r[31], r};
        else        dir_res = imm_shift(in_shift_type, in_shift_imm, rm_val, cpsr_c);
    end

    assign rs_res = reg_shift(lat.stype, lat.rs, lat.rm, lat.c);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state      <= EMPTY;
            lat        <= '0;
            out_opcode <= '0;
            out_a      <= '0;
            out_b      <= '0;
            out_shc    <= 1'b0;
        end else begin
            case (state)
                RSHIFT: begin
                    out_opcode       <= lat.opcode;
                    out_a            <= lat.rn;
                    {out_shc, out_b} <= rs_res;
                    state            <= FULL;
                end
                EMPTY, FULL: begin
                    if (accept) begin
                        if (is_reg) begin
                            lat   <= '{opcode: in_opcode, rn: rn_val, rm: rm_val,
                                       rs: rs_val[7:0], stype: in_shift_type, c: cpsr_c};
                            state <= RSHIFT;
                        end else begin
                            out_opcode       <= in_opcode;
                            out_a            <= rn_val;
                            {out_shc, out_b} <= dir_res;
                            state            <= FULL;
                        end
                    end else if ((state == FULL) && out_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_shifter_stage.sv
// Bench for shifter_stage: directed vector table, randomized ops against an iterative
// shift model, plus backpressure, flush and reset sequences.
module tb_shifter_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, in_imm, in_shift_reg, cpsr_c;
    logic        out_valid, out_ready, out_shc;
    logic [3:0]  in_opcode, in_rot, out_opcode;
    logic [7:0]  in_imm8;
    logic [1:0]  in_shift_type;
    logic [4:0]  in_shift_imm;
    logic [31:0] rn_val, rm_val, rs_val, out_a, out_b;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        imm;
        logic [7:0]  imm8;
        logic [3:0]  rot;
        logic        sreg;
        logic [1:0]  st;
        logic [4:0]  simm;
        logic [31:0] rm;
        logic [31:0] rs;
        logic        c;
        logic [31:0] exp_b;
        logic        exp_c;
    } vec_t;

    shifter_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_imm(in_imm), .in_imm8(in_imm8), .in_rot(in_rot),
        .in_shift_reg(in_shift_reg), .in_shift_type(in_shift_type),
        .in_shift_imm(in_shift_imm), .rn_val(rn_val), .rm_val(rm_val), .rs_val(rs_val),
        .cpsr_c(cpsr_c), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_a(out_a), .out_b(out_b), .out_shc(out_shc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic imm, input logic [7:0] imm8, input logic [3:0] rot,
                                input logic sreg, input logic [1:0] st, input logic [4:0] simm,
                                input logic [31:0] rm, input logic [31:0] rs, input logic c,
                                input logic [31:0] eb, input logic ec);
        vec_t v;
        v.imm = imm; v.imm8 = imm8; v.rot = rot; v.sreg = sreg; v.st = st; v.simm = simm;
        v.rm = rm; v.rs = rs; v.c = c; v.exp_b = eb; v.exp_c = ec;
        return v;
    endfunction

    // Reference: apply the shift one bit position at a time, carry = last bit shifted out.
    function automatic logic [32:0] model(input vec_t v);
        logic [31:0] x;
        logic        car;
        int          n;
        if (v.imm) begin
            x = {24'h0, v.imm8};
            for (int i = 0; i < 2 * int'(v.rot); i++) x = {x[0], x[31:1]};
            car = (v.rot == 0) ? v.c : x[31];
            return {car, x};
        end
        x   = v.rm;
        car = v.c;
        n   = v.sreg ? int'(v.rs[7:0]) : int'(v.simm);
        if (!v.sreg && n == 0) begin
            if (v.st == 2'b01 || v.st == 2'b10) n = 32;
            else if (v.st == 2'b11) return {v.rm[0], v.c, v.rm[31:1]};
        end
        for (int i = 0; i < n; i++) begin
            case (v.st)
                2'b00:   begin car = x[31]; x = x << 1; end
                2'b01:   begin car = x[0];  x = x >> 1; end
                2'b10:   begin car = x[0];  x = {x[31], x[31:1]}; end
                default: begin car = x[0];  x = {x[0], x[31:1]}; end
            endcase
        end
        return {car, x};
    endfunction

    task automatic drive(input vec_t v, input logic [3:0] opc, input logic [31:0] rn);
        in_imm = v.imm; in_imm8 = v.imm8; in_rot = v.rot; in_shift_reg = v.sreg;
        in_shift_type = v.st; in_shift_imm = v.simm; rm_val = v.rm; rs_val = v.rs;
        cpsr_c = v.c; in_opcode = opc; rn_val = rn;
    endtask

    // One transaction from EMPTY with out_ready high; checks latency and the result.
    task automatic do_op(input vec_t v, input logic [3:0] opc, input logic [31:0] rn,
                         input string tag);
        int lat;
        int exp_lat;
        exp_lat = (v.sreg && !v.imm) ? 2 : 1;
        drive(v, opc, rn);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({tag, " in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble the operands after accept: the stage must use what it captured.
        cpsr_c = ~v.c; rm_val = ~v.rm; rs_val = ~v.rs; rn_val = ~rn;
        lat = 1;
        if (exp_lat == 2) chk({tag, " in_ready_rshift"}, in_ready, 0);
        while (!out_valid && lat < 6) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " b"}, out_b, v.exp_b);
        chk({tag, " shc"}, out_shc, v.exp_c);
        chk({tag, " a"}, out_a, rn);
        chk({tag, " opcode"}, out_opcode, opc);
        @(posedge clk); #1;
    endtask

    vec_t tbl[13];
    vec_t bp[3];
    vec_t r;
    logic [32:0] m;

    initial begin
        tbl[0]  = mk(1, 8'hFF, 4, 0, 0, 0, 0, 0, 0, 32'hFF000000, 1);
        tbl[1]  = mk(0, 0, 0, 0, 2'b01, 0, 32'h80000001, 0, 1, 32'h00000000, 1);
        tbl[2]  = mk(0, 0, 0, 0, 2'b10, 0, 32'h80000001, 0, 1, 32'hFFFFFFFF, 1);
        tbl[3]  = mk(0, 0, 0, 0, 2'b11, 0, 32'h80000001, 0, 1, 32'hC0000000, 1);
        tbl[4]  = mk(0, 0, 0, 0, 2'b00, 0, 32'h80000001, 0, 1, 32'h80000001, 1);
        tbl[5]  = mk(0, 0, 0, 1, 2'b00, 0, 32'h80000001, 32, 0, 32'h00000000, 1);
        tbl[6]  = mk(0, 0, 0, 1, 2'b00, 0, 32'h80000001, 33, 1, 32'h00000000, 0);
        tbl[7]  = mk(0, 0, 0, 1, 2'b11, 0, 32'h80000001, 32'h20, 0, 32'h80000001, 1);
        tbl[8]  = mk(0, 0, 0, 1, 2'b00, 0, 32'h80000001, 32'h100, 0, 32'h80000001, 0);
        tbl[9]  = mk(0, 0, 0, 1, 2'b10, 0, 32'h80000001, 40, 0, 32'hFFFFFFFF, 1);
        tbl[10] = mk(0, 0, 0, 1, 2'b01, 0, 32'h80000001, 32, 0, 32'h00000000, 1);
        tbl[11] = mk(0, 0, 0, 0, 2'b01, 1, 32'h80000001, 0, 0, 32'h40000000, 1);
        tbl[12] = mk(1, 8'h5A, 0, 1, 0, 0, 0, 0, 1, 32'h0000005A, 1);

        rst = 1; flush = 0; in_valid = 0; out_ready = 0;
        drive(tbl[0], 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("reset out_valid", out_valid, 0);
        chk("reset in_ready", in_ready, 1);
        chk("reset out_b", out_b, 0);
        chk("reset out_a", out_a, 0);
        chk("reset out_opcode", out_opcode, 0);
        chk("reset out_shc", out_shc, 0);

        for (int i = 0; i < 13; i++)
            do_op(tbl[i], 4'(i + 1), 32'h1000 + i, $sformatf("vec%0d", i));

        for (int i = 0; i < 150; i++) begin
            r.imm = 1'($urandom_range(0, 3) == 0);
            r.imm8 = 8'($urandom); r.rot = 4'($urandom); r.sreg = 1'($urandom);
            r.st = 2'($urandom); r.simm = 5'($urandom); r.rm = $urandom; r.c = 1'($urandom);
            r.rs = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            m = model(r);
            r.exp_b = m[31:0]; r.exp_c = m[32];
            do_op(r, 4'($urandom), $urandom, $sformatf("rnd%0d", i));
        end

        // Backpressure: three imm-shift ops, output stalled for three cycles.
        for (int i = 0; i < 3; i++) begin
            bp[i] = mk(0, 0, 0, 0, 2'b00, 5'(i + 1), 32'h0000000F << (4 * i), 0, 0, 0, 0);
            m = model(bp[i]);
            bp[i].exp_b = m[31:0]; bp[i].exp_c = m[32];
        end
        begin
            int idx, oi, cyc;
            logic acc, con;
            idx = 0; oi = 0; cyc = 0;
            while (oi < 3 && cyc < 20) begin
                in_valid = (idx < 3);
                if (idx < 3) drive(bp[idx], 4'(idx), 32'(idx));
                out_ready = !(cyc >= 1 && cyc <= 3);
                #1;
                acc = in_valid && in_ready;
                con = out_valid && out_ready;
                if (out_valid) chk($sformatf("bp out_b cyc%0d", cyc), out_b, bp[oi].exp_b);
                if (con) oi++;
                if (acc) idx++;
                @(posedge clk); #1;
                cyc++;
            end
            in_valid = 0;
            chk("bp drained", oi, 3);
            chk("bp drain cycles", cyc, 7);
            chk("bp no dup", out_valid, 0);
        end

        // Flush while in RSHIFT; concurrent offer must be dropped.
        out_ready = 1;
        drive(tbl[5], 4'h3, 32'h55);
        in_valid = 1;
        @(posedge clk); #1;
        drive(tbl[0], 4'h4, 32'h66);
        flush = 1;
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        chk("flush_rs out_valid", out_valid, 0);
        chk("flush_rs in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1 chk("flush_rs discarded", out_valid, 0);

        // Flush while FULL with out_ready high, so the offer would otherwise be taken.
        drive(tbl[1], 4'h5, 32'h77);
        in_valid = 1;
        @(posedge clk); #1;
        chk("flush_full pre valid", out_valid, 1);
        drive(tbl[0], 4'h6, 32'h88);
        flush = 1;
        @(posedge clk); #1;
        flush = 0; in_valid = 0;
        chk("flush_full out_valid", out_valid, 0);
        chk("flush_full in_ready", in_ready, 1);
        chk("flush_full out_a", out_a, 0);
        @(posedge clk); #1;
        chk("flush_full dropped", out_valid, 0);

        // Reset while FULL and stalled.
        out_ready = 0;
        drive(tbl[0], 4'h9, 32'hABCD);
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        chk("rst_full pre valid", out_valid, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("rst_full out_valid", out_valid, 0);
        chk("rst_full out_b", out_b, 0);
        chk("rst_full out_a", out_a, 0);
        chk("rst_full out_opcode", out_opcode, 0);
        chk("rst_full out_shc", out_shc, 0);
        chk("rst_full in_ready", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
